// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry and exit, tracks lot occupancy
module parking_gate_arbiter #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int PASS_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             pass_sensor,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);
    localparam int TW = $clog2(PASS_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, OPEN_IN, PASS_IN, OPEN_OUT, PASS_OUT, CLOSE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [CNT_W-1:0] occ_nx;
    logic last_exit, last_exit_nx, to_flag, to_nx;
    logic entry_ok, exit_ok;
    assign full        = occupancy == CNT_W'(CAPACITY);
    assign empty       = occupancy == '0;
    assign entry_ok    = entry_req && !full;
    assign exit_ok     = exit_req && !empty;
    assign gate_open   = state inside {OPEN_IN, PASS_IN, OPEN_OUT, PASS_OUT};
    assign entry_grant = state == OPEN_IN && timer == TW'(1);
    assign exit_grant  = state == OPEN_OUT && timer == TW'(1);
    assign timeout_err = to_flag;
    // register FSM state, wait timer, occupancy, round-robin pointer and timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            timer     <= '0;
            occupancy <= '0;
            last_exit <= 1'b0;
            to_flag   <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            occupancy <= occ_nx;
            last_exit <= last_exit_nx;
            to_flag   <= to_nx;
        end
    end
    // next-state: grant in IDLE, wait for the car while open, count it out of PASS
    always_comb begin
        state_nx     = state;
        timer_nx     = '0;
        occ_nx       = occupancy;
        last_exit_nx = last_exit;
        to_nx        = 1'b0;
        case (state)
            IDLE: if (entry_ok || exit_ok) begin
                last_exit_nx = exit_ok && (!entry_ok || !last_exit);
                state_nx     = last_exit_nx ? OPEN_OUT : OPEN_IN;
                timer_nx     = TW'(1);
            end
            OPEN_IN, OPEN_OUT: if (pass_sensor) begin
                state_nx = state == OPEN_IN ? PASS_IN : PASS_OUT;
            end else if (timer == TW'(PASS_TIMEOUT)) begin
                state_nx = CLOSE;
                to_nx    = 1'b1;
            end else begin
                timer_nx = timer + TW'(1);
            end
            PASS_IN: if (!pass_sensor) begin
                state_nx = CLOSE;
                occ_nx   = full ? occupancy : occupancy + CNT_W'(1);
            end
            PASS_OUT: if (!pass_sensor) begin
                state_nx = CLOSE;
                occ_nx   = empty ? occupancy : occupancy - CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: random stimulus against a behavioural gate/occupancy model
module tb_parking_gate_arbiter;
    localparam int CAP = 3;
    localparam int CW  = 3;
    localparam int PT  = 4;
    logic clk = 1'b0;
    logic reset_n, entry_req, exit_req, pass_sensor;
    logic entry_grant, exit_grant, gate_open, full, empty, timeout_err;
    logic [CW-1:0] occupancy;
    int checks = 0;
    int errors = 0;
    int m_occ, m_phase, m_wait;
    bit m_out, m_last_out, m_to;
    int sens_pct;
    bit e_lvl, x_lvl;

    parking_gate_arbiter #(.CAPACITY(CAP), .CNT_W(CW), .PASS_TIMEOUT(PT)) dut (
        .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
        .pass_sensor(pass_sensor), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .gate_open(gate_open), .occupancy(occupancy), .full(full), .empty(empty),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_phase = 0; m_wait = 0; m_out = 0; m_last_out = 0; m_to = 0;
    endtask

    task automatic compare_all();
        check("gate_open", gate_open, m_phase == 1 || m_phase == 2);
        check("entry_grant", entry_grant, m_phase == 1 && !m_out && m_wait == 1);
        check("exit_grant", exit_grant, m_phase == 1 && m_out && m_wait == 1);
        check("timeout_err", timeout_err, m_phase == 3 && m_to);
        check("occupancy", occupancy, m_occ);
        check("full", full, m_occ == CAP);
        check("empty", empty, m_occ == 0);
    endtask

    // phases: 0 gate closed and free, 1 raised awaiting car, 2 car in lane, 3 closing
    task automatic model_step();
        bit e, x;
        case (m_phase)
            0: begin
                e = entry_req && m_occ < CAP;
                x = exit_req && m_occ > 0;
                if (e || x) begin
                    m_out = x && !(e && m_last_out);
                    m_last_out = m_out;
                    m_phase = 1;
                    m_wait = 1;
                end
            end
            1: if (pass_sensor) m_phase = 2;
               else if (m_wait == PT) begin m_phase = 3; m_to = 1; end
               else m_wait++;
            2: if (!pass_sensor) begin
                m_occ = m_out ? (m_occ > 0 ? m_occ - 1 : 0) : (m_occ < CAP ? m_occ + 1 : CAP);
                m_phase = 3;
                m_to = 0;
            end
            default: begin m_phase = 0; m_to = 0; end
        endcase
    endtask

    task automatic drive_cycle(input bit e, input bit x, input bit s);
        compare_all();
        entry_req = e; exit_req = x; pass_sensor = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0: sens_pct = 0;
                    1: sens_pct = 30;
                    2: sens_pct = 70;
                    default: sens_pct = 100;
                endcase
            end
            if ($urandom_range(0, 7) == 0) e_lvl = ~e_lvl;
            if ($urandom_range(0, 7) == 0) x_lvl = ~x_lvl;
            drive_cycle(e_lvl, x_lvl, $urandom_range(0, 99) < sens_pct);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; pass_sensor = 1'b0;
        e_lvl = 0; x_lvl = 0; sens_pct = 50;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) drive_cycle(0, 1, i[0]);
        drive_cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) drive_cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0);
        random_run(3000);
        n = 0;
        while (!(m_phase == 2 && m_occ > 0) && n < 300) begin
            drive_cycle(1, 1, $urandom_range(0, 1) == 1);
            n++;
        end
        if (n == 300) check("reach_pass", 0, 1);
        else begin
            pass_sensor = 1'b1;
            #2 reset_n = 1'b0;
            #1;
            check("rst_gate_open", gate_open, 0);
            check("rst_occupancy", occupancy, 0);
            check("rst_empty", empty, 1);
            check("rst_entry_grant", entry_grant, 0);
            check("rst_exit_grant", exit_grant, 0);
            check("rst_timeout", timeout_err, 0);
            model_reset();
            @(negedge clk);
            compare_all();
            reset_n = 1'b1;
        end
        random_run(1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Arbitrates the single-lane barrier gate shared by the entrance and exit paths of the parking system, and tracks lot occupancy. The entrance-side password controller raises `entry_req` once a car is authenticated; the exit-side detector raises `exit_req`. The block grants the gate to one direction at a time, sequences the barrier through open, pass and close, and counts cars in and out against a fixed capacity.

## Interface
- `CAPACITY`, default 8: number of parking spaces; must be at least 1.
- `CNT_W`, default 4: occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- `PASS_TIMEOUT`, default 16: maximum number of cycles the gate waits in an open state for a vehicle to arrive; must be at least 2.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `entry_req` in 1: level request; an authenticated car is waiting at the entrance; held until served.
- `exit_req` in 1: level request; a car is waiting to exit.
- `pass_sensor` in 1: lane sensor; high while a vehicle occupies the gate.
- `entry_grant` out 1: one-cycle pulse when the gate is granted to the entrance.
- `exit_grant` out 1: one-cycle pulse when the gate is granted to the exit.
- `gate_open` out 1: barrier drive; 1 means raised.
- `occupancy` out CNT_W: number of cars currently inside.
- `full` out 1: high when `occupancy` equals `CAPACITY`.
- `empty` out 1: high when `occupancy` equals 0.
- `timeout_err` out 1: one-cycle pulse when a grant expires with no vehicle passing.

## Operation
- Moore FSM with states IDLE, OPEN_IN, PASS_IN, OPEN_OUT, PASS_OUT, CLOSE. All outputs are decoded from registers.
- Eligibility: entry is eligible when `entry_req` is high and `full` is low. Exit is eligible when `exit_req` is high and `empty` is low.
- IDLE:
  - Only entry eligible: go to OPEN_IN.
  - Only exit eligible: go to OPEN_OUT.
  - Both eligible: grant the direction not served last (round-robin). After reset, exit has priority.
  - `last_dir` updates on every grant.
- OPEN_x:
  - The wait timer starts at 1 in the first cycle of the state.
  - `pass_sensor` = 1: go to PASS_x.
  - Timer = PASS_TIMEOUT with `pass_sensor` = 0: go to CLOSE and pulse `timeout_err` in the CLOSE cycle. Occupancy is unchanged.
- PASS_x:
  - Wait with no timeout until `pass_sensor` = 0.
  - Then go to CLOSE, adding 1 to occupancy for IN or subtracting 1 for OUT on that same edge.
- CLOSE: lasts exactly one cycle, then returns to IDLE. This guarantees at least one closed-gate cycle between vehicles.
- `gate_open` is 1 in OPEN_x and PASS_x, and 0 otherwise.
- `entry_grant` / `exit_grant` are high only in the first cycle of OPEN_IN / OPEN_OUT.
- Requests are ignored outside IDLE and are not queued; requesters hold their level.
- Occupancy saturates at 0 and at CAPACITY. This is defensive only, since eligibility already prevents over- and underflow.
- `full` and `empty` are combinational compares on the `occupancy` register.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, `occupancy` = 0, timer = 0, `last_dir` = entry (so exit wins first contention).
  - Outputs: `gate_open` = 0, both grants = 0, `timeout_err` = 0, `full` = 0, `empty` = 1.
- Reset mid-operation closes the gate and clears occupancy at once. Release is synchronous to the next edge.
- Grant latency: request sampled high in IDLE at edge k; grant pulse and `gate_open` are high in the cycle after edge k.
- Occupancy changes on the edge leaving PASS_x and is visible during the CLOSE cycle.
- Minimum full transaction: 1 (OPEN) + n (PASS) + 1 (CLOSE) cycles. The next grant can come at the earliest one cycle after CLOSE.
- Timeout path: OPEN_x lasts exactly PASS_TIMEOUT cycles, then 1 CLOSE cycle with `timeout_err` = 1.
- A `pass_sensor` glitch in IDLE or CLOSE is ignored.
- A request that becomes ineligible (lot turns full) before IDLE samples it is not granted.

## Test plan
- Reset, then `entry_req` = 1 with `pass_sensor` high for 3 cycles after the grant:
  - `entry_grant` pulses 1 cycle after the request.
  - `gate_open` is high for 1 + 3 cycles.
  - `occupancy` becomes 1 in the CLOSE cycle and `empty` drops.
- CAPACITY = 2, two entries completed, then `entry_req` = 1:
  - `full` = 1, no grant, `gate_open` stays 0.
  - Assert `exit_req`: the exit is granted and `occupancy` returns to 1.
- `entry_req` and `exit_req` both high continuously, occupancy = 1:
  - First grant goes to exit, the next to entry.
  - Grants alternate thereafter, separated by CLOSE plus IDLE cycles.
- PASS_TIMEOUT = 4, `entry_req` = 1 with `pass_sensor` held 0:
  - `gate_open` is high exactly 4 cycles.
  - `timeout_err` pulses once and `occupancy` is unchanged.
- Assert `reset_n` = 0 during PASS_IN with occupancy = 3:
  - `gate_open`, `occupancy` and grants go to 0 immediately, without waiting for a clock edge.
  - `empty` = 1.
- `exit_req` = 1 right after reset:
  - `empty` = 1 blocks it; no grant and no `timeout_err`.
  - `pass_sensor` pulses in IDLE have no effect.
